// File: rtl/icf3z_iodev.sv
// I/O peripheral for a small CPU port bus: GPO, synchronised GPI, status and interrupts.
// The reload down-counter timer is present only when ICF3Z_IODEV_TIMER_EN is defined.
module icf3z_iodev (
   input  logic       CLK,
   input  logic       xRESET_P,
   input  logic [7:0] xPORTID_P,
   input  logic [7:0] xOUTPORT_P,
   input  logic       xWSTROBE_P,
   input  logic       xWSTROBEK_P,
   input  logic       xIOSTROBE_P,
   input  logic       xRSTROBE_P,
   input  logic [7:0] xGPI_P,
   output logic [7:0] xINPORT_P,
   output logic       xINT0_P,
   output logic       xINT1_P,
   output logic [7:0] xGPO_P
);

   logic       wr;
   logic [7:0] gpo_q, gpo_d;
   logic [7:0] s1_q, s2_q;
   logic [1:0] stat_q, stat_d;
   logic [1:0] ien_q, ien_d;
   logic [1:0] prev_q;
   logic [1:0] rise;
   logic [1:0] pc0_q, pc0_d;
   logic [1:0] pc1_q, pc1_d;
   logic [7:0] inport_q, inport_d;
   logic       tmr_set;
   logic       gpie_set;
   logic       unused_strobes;

   // Reads have no side effects, so these strobes carry no information here.
   assign unused_strobes = xIOSTROBE_P ^ xRSTROBE_P;

   assign wr       = (xWSTROBE_P | xWSTROBEK_P) & ~xRESET_P;
   assign gpie_set = s1_q[0] & ~s2_q[0];

`ifdef ICF3Z_IODEV_TIMER_EN
   logic [7:0] reload_q, reload_d;
   logic [7:0] cnt_q, cnt_d;
   logic       en_q, en_d;
   logic       auto_q, auto_d;

   always_comb begin
      reload_d = reload_q;
      cnt_d    = cnt_q;
      en_d     = en_q;
      auto_d   = auto_q;
      tmr_set  = 1'b0;
      if (wr && xPORTID_P == 8'h02) reload_d = xOUTPORT_P;
      // A CTL write pre-empts an expiry landing in the same cycle.
      if (wr && xPORTID_P == 8'h03) begin
         en_d   = xOUTPORT_P[0];
         auto_d = xOUTPORT_P[1];
         if (xOUTPORT_P[0]) cnt_d = reload_q;
      end else if (en_q) begin
         if (cnt_q == 8'h00) begin
            tmr_set = 1'b1;
            cnt_d   = reload_q;
            if (!auto_q) en_d = 1'b0;
         end else begin
            cnt_d = cnt_q - 8'd1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (xRESET_P) begin
         reload_q <= 8'h00;
         cnt_q    <= 8'h00;
         en_q     <= 1'b0;
         auto_q   <= 1'b0;
      end else begin
         reload_q <= reload_d;
         cnt_q    <= cnt_d;
         en_q     <= en_d;
         auto_q   <= auto_d;
      end
   end

   assign xINT0_P = |pc0_q;
`else
   assign tmr_set = 1'b0;
   assign xINT0_P = 1'b0;
`endif

   always_comb begin
      gpo_d  = gpo_q;
      ien_d  = ien_q;
      stat_d = stat_q;
      if (wr && xPORTID_P == 8'h00) gpo_d = xOUTPORT_P;
      if (wr && xPORTID_P == 8'h05) ien_d = xOUTPORT_P[1:0];
      if (wr && xPORTID_P == 8'h04) stat_d = stat_q & ~xOUTPORT_P[1:0];
      stat_d = stat_d | {gpie_set, tmr_set};
   end

   // A pulse in flight ignores new rises; the STAT bit alone records them.
   always_comb begin
      rise  = stat_q & ~prev_q & ien_q;
      pc0_d = 2'd0;
      pc1_d = 2'd0;
      if (pc0_q != 2'd0) pc0_d = pc0_q - 2'd1;
      else if (rise[0]) pc0_d = 2'd3;
      if (pc1_q != 2'd0) pc1_d = pc1_q - 2'd1;
      else if (rise[1]) pc1_d = 2'd3;
   end

   always_comb begin
      inport_d = 8'h00;
      case (xPORTID_P)
         8'h00:   inport_d = gpo_q;
         8'h01:   inport_d = s2_q;
`ifdef ICF3Z_IODEV_TIMER_EN
         8'h02:   inport_d = reload_q;
         8'h03:   inport_d = {6'b0, auto_q, en_q};
`endif
         8'h04:   inport_d = {6'b0, stat_q};
         8'h05:   inport_d = {6'b0, ien_q};
         default: inport_d = 8'h00;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (xRESET_P) begin
         gpo_q    <= 8'h00;
         s1_q     <= 8'h00;
         s2_q     <= 8'h00;
         stat_q   <= 2'b00;
         ien_q    <= 2'b00;
         prev_q   <= 2'b00;
         pc0_q    <= 2'd0;
         pc1_q    <= 2'd0;
         inport_q <= 8'h00;
      end else begin
         gpo_q    <= gpo_d;
         s1_q     <= xGPI_P;
         s2_q     <= s1_q;
         stat_q   <= stat_d;
         ien_q    <= ien_d;
         prev_q   <= stat_q;
         pc0_q    <= pc0_d;
         pc1_q    <= pc1_d;
         inport_q <= inport_d;
      end
   end

   assign xINPORT_P = inport_q;
   assign xINT1_P   = |pc1_q;
   assign xGPO_P    = gpo_q;

endmodule

// File: tb/tb_icf3z_iodev.sv
// Scoreboard bench for icf3z_iodev: stimulus queues cycle-tagged expectations,
// a negedge monitor pops and compares them. Timer cases follow ICF3Z_IODEV_TIMER_EN.
module tb_icf3z_iodev;

   logic       CLK = 1'b0;
   logic       rst;
   logic [7:0] id, dout, gpi;
   logic       ws, wk, ios, rs;
   logic [7:0] inport, gpo;
   logic       int0, int1;

   icf3z_iodev dut (
      .CLK         (CLK),
      .xRESET_P    (rst),
      .xPORTID_P   (id),
      .xOUTPORT_P  (dout),
      .xWSTROBE_P  (ws),
      .xWSTROBEK_P (wk),
      .xIOSTROBE_P (ios),
      .xRSTROBE_P  (rs),
      .xGPI_P      (gpi),
      .xINPORT_P   (inport),
      .xINT0_P     (int0),
      .xINT1_P     (int1),
      .xGPO_P      (gpo)
   );

   always #5 CLK = ~CLK;

   localparam int K_IN  = 0;
   localparam int K_GPO = 1;
   localparam int K_I0  = 2;
   localparam int K_I1  = 3;

   typedef struct {
      int         cyc;
      int         kind;
      logic [7:0] val;
   } sb_t;

   sb_t sb[$];
   sb_t e;
   int  cyc    = 0;
   int  n_chk  = 0;
   int  n_fail = 0;
   int  b, g, h;

   always @(posedge CLK) cyc <= cyc + 1;

   function automatic logic [7:0] actual(int k);
      case (k)
         K_IN:    return inport;
         K_GPO:   return gpo;
         K_I0:    return {7'b0, int0};
         default: return {7'b0, int1};
      endcase
   endfunction

   function automatic string kname(int k);
      case (k)
         K_IN:    return "INPORT";
         K_GPO:   return "GPO";
         K_I0:    return "INT0";
         default: return "INT1";
      endcase
   endfunction

   task automatic chk_at(input int c, input int k, input logic [7:0] v);
      int i;
      i = 0;
      while (i < sb.size() && sb[i].cyc <= c) i++;
      sb.insert(i, '{cyc: c, kind: k, val: v});
   endtask

   always @(negedge CLK) begin
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         n_chk++;
         if (e.cyc != cyc) begin
            n_fail++;
            $display("FAIL %s@%0d missed, now cycle %0d",
                     kname(e.kind), e.cyc, cyc);
         end else if (actual(e.kind) !== e.val) begin
            n_fail++;
            $display("FAIL %s@%0d got %02h expected %02h",
                     kname(e.kind), e.cyc, actual(e.kind), e.val);
         end
      end
   end

   task automatic step();
      @(posedge CLK);
      #1;
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      id   = a;
      dout = d;
      ws   = 1'b1;
      step();
      ws   = 1'b0;
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] v);
      id = a;
      chk_at(cyc + 1, K_IN, v);
      step();
   endtask

   initial begin
      rst = 1'b1; id = 8'h00; dout = 8'hFF; gpi = 8'h00;
      ws = 1'b1; wk = 1'b0; ios = 1'b0; rs = 1'b0;
      // strobe held through reset must be ignored
      step();
      step();
      chk_at(cyc, K_GPO, 8'h00);
      chk_at(cyc, K_IN, 8'h00);
      chk_at(cyc, K_I0, 8'h00);
      chk_at(cyc, K_I1, 8'h00);
      ws = 1'b0; rst = 1'b0;
      step();

      id = 8'h00; dout = 8'hA5; wk = 1'b1;
      chk_at(cyc + 1, K_GPO, 8'hA5);
      step();
      wk = 1'b0;
      rd(8'h00, 8'hA5);

      id = 8'h00; dout = 8'h3C; ws = 1'b1; wk = 1'b1;
      chk_at(cyc + 1, K_GPO, 8'h3C);
      step();
      ws = 1'b0; wk = 1'b0;
      wr(8'h07, 8'hFF);
      rd(8'h07, 8'h00);
      rd(8'h00, 8'h3C);
      wr(8'h05, 8'hFF);
      rd(8'h05, 8'h03);

      rs = 1'b1; ios = 1'b1; id = 8'h04; dout = 8'h00;
      step();
      step();
      rs = 1'b0; ios = 1'b0;
      rd(8'h00, 8'h3C);
      rd(8'h01, 8'h00);

`ifdef ICF3Z_IODEV_TIMER_EN
      // one-shot, reload 2
      wr(8'h05, 8'h00);
      wr(8'h02, 8'h02);
      rd(8'h02, 8'h02);
      wr(8'h03, 8'h01);
      b = cyc; id = 8'h04;
      chk_at(b + 3, K_IN, 8'h00);
      chk_at(b + 4, K_IN, 8'h01);
      chk_at(b + 4, K_I0, 8'h00);
      repeat (5) step();
      rd(8'h03, 8'h00);
      wr(8'h04, 8'h01);
      rd(8'h04, 8'h00);

      // auto-reload, period 5
      wr(8'h02, 8'h04);
      wr(8'h05, 8'h01);
      wr(8'h03, 8'h03);
      b = cyc; id = 8'h04; dout = 8'h01;
      chk_at(b + 5,  K_I0, 8'h00);
      chk_at(b + 6,  K_I0, 8'h01);
      chk_at(b + 7,  K_I0, 8'h01);
      chk_at(b + 8,  K_I0, 8'h01);
      chk_at(b + 9,  K_I0, 8'h00);
      chk_at(b + 10, K_I0, 8'h00);
      chk_at(b + 11, K_I0, 8'h01);
      chk_at(b + 13, K_I0, 8'h01);
      chk_at(b + 14, K_I0, 8'h00);
      chk_at(b + 16, K_I0, 8'h00);
      chk_at(b + 21, K_I0, 8'h00);
      chk_at(b + 5,  K_IN, 8'h00);
      chk_at(b + 6,  K_IN, 8'h01);
      chk_at(b + 9,  K_IN, 8'h00);
      chk_at(b + 10, K_IN, 8'h00);
      chk_at(b + 11, K_IN, 8'h01);
      chk_at(b + 16, K_IN, 8'h01);
      chk_at(b + 18, K_IN, 8'h01);
      chk_at(b + 19, K_IN, 8'h00);
      chk_at(b + 21, K_IN, 8'h00);
      repeat (7) step();
      ws = 1'b1; step(); ws = 1'b0;
      repeat (6) step();
      // W1C lands on the expiry edge
      ws = 1'b1; step(); ws = 1'b0;
      repeat (2) step();
      ws = 1'b1; step(); ws = 1'b0;
      step();
      // CTL write lands on the expiry edge
      id = 8'h03; dout = 8'h00; ws = 1'b1;
      step();
      ws = 1'b0; id = 8'h04;
      step();
      rd(8'h03, 8'h00);
`else
      wr(8'h02, 8'h55);
      wr(8'h05, 8'h01);
      wr(8'h03, 8'h03);
      rd(8'h02, 8'h00);
      rd(8'h03, 8'h00);
      b = cyc; id = 8'h04;
      for (int i = 1; i <= 8; i++) chk_at(b + i, K_I0, 8'h00);
      chk_at(b + 8, K_IN, 8'h00);
      repeat (8) step();
`endif

      // GPI edge, W1C and a second edge inside the pulse
      wr(8'h05, 8'h02);
      id = 8'h04; dout = 8'h02; g = cyc; gpi = 8'h01;
      chk_at(g + 2, K_I1, 8'h00);
      chk_at(g + 3, K_I1, 8'h01);
      chk_at(g + 4, K_I1, 8'h01);
      chk_at(g + 5, K_I1, 8'h01);
      chk_at(g + 6, K_I1, 8'h00);
      chk_at(g + 7, K_I1, 8'h00);
      chk_at(g + 2, K_IN, 8'h00);
      chk_at(g + 3, K_IN, 8'h02);
      chk_at(g + 4, K_IN, 8'h00);
      chk_at(g + 5, K_IN, 8'h02);
      step();
      gpi = 8'h00;
      step();
      gpi = 8'h01; ws = 1'b1;
      step();
      ws = 1'b0;
      repeat (5) step();
      rd(8'h01, 8'h01);
      wr(8'h04, 8'h02);
      rd(8'h04, 8'h00);

      // reset in the middle of a pulse and a count
      gpi = 8'h00;
      repeat (3) step();
      wr(8'h00, 8'h5A);
      wr(8'h05, 8'h03);
`ifdef ICF3Z_IODEV_TIMER_EN
      wr(8'h02, 8'h10);
      wr(8'h03, 8'h03);
`endif
      wr(8'h04, 8'h03);
      id = 8'h04; h = cyc; gpi = 8'h01;
      chk_at(h + 3, K_I1, 8'h01);
      chk_at(h + 3, K_GPO, 8'h5A);
      repeat (3) step();
      rst = 1'b1; ws = 1'b1; id = 8'h00; dout = 8'hFF;
      chk_at(h + 4, K_GPO, 8'h00);
      chk_at(h + 4, K_IN, 8'h00);
      chk_at(h + 4, K_I0, 8'h00);
      chk_at(h + 4, K_I1, 8'h00);
      step();
      rst = 1'b0; ws = 1'b0; id = 8'h04;
      chk_at(h + 6, K_IN, 8'h00);
      chk_at(h + 7, K_IN, 8'h02);
      chk_at(h + 6, K_GPO, 8'h00);
      for (int i = 5; i <= 8; i++) chk_at(h + i, K_I1, 8'h00);
      repeat (5) step();
      rd(8'h03, 8'h00);

      repeat (50) begin
         if (sb.size() == 0) break;
         step();
      end
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_chk++;
         n_fail++;
         $display("FAIL %s@%0d never sampled", kname(e.kind), e.cyc);
      end
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/icf3z_iodev.md
ICF3Z_IODEV -- requirements
Module: icf3z_iodev

Interface
REQ-001 SHALL have ports: CLK  in  1  single system clock; all state changes on rising edge.
REQ-002 SHALL have: xRESET_P  in  1  reset, synchronous, active-high.
REQ-003 SHALL have: xPORTID_P  in  8  port address from CPU.
REQ-004 SHALL have: xOUTPORT_P  in  8  write data from CPU.
REQ-005 SHALL have: xWSTROBE_P  in  1  register write strobe; xWSTROBEK_P  in  1  constant-write strobe; xIOSTROBE_P  in  1  I/O cycle qualifier, ignored; xRSTROBE_P  in  1  read strobe.
REQ-006 SHALL have: xGPI_P  in  8  asynchronous general-purpose inputs.
REQ-007 SHALL have: xINPORT_P  out  8  read data to CPU; xINT0_P  out  1  timer interrupt; xINT1_P  out  1  GPI interrupt; xGPO_P  out  8  general-purpose outputs.

Function
REQ-008 SHALL decode xPORTID_P: 0x00 GPO R/W; 0x01 GPI R; 0x02 RELOAD R/W; 0x03 CTL R/W (bit0 EN, bit1 AUTO, bits7:2 read 0); 0x04 STAT R/W1C (bit0 TMR, bit1 GPIE); 0x05 IEN R/W (bit0, bit1); other ids read 0x00, writes discarded.
REQ-009 SHALL commit a write in the cycle xWSTROBE_P or xWSTROBEK_P is high, using xPORTID_P/xOUTPORT_P of that cycle; both high same cycle = one write.
REQ-010 SHALL register xINPORT_P every cycle from the xPORTID_P decode: 1-cycle latency, no strobe required.
REQ-011 SHALL pass xGPI_P through a 2-flop synchronizer; GPI read returns synchronized value.
REQ-012 SHALL set STAT.GPIE on a synchronized 0->1 transition of xGPI_P[0].
REQ-013 SHALL hold an 8-bit down-counter CNT: write CTL with EN=1 loads CNT=RELOAD; while EN=1, CNT==0 sets STAT.TMR and reloads RELOAD, else CNT decrements; period = RELOAD+1 cycles (RELOAD=0 -> every cycle).
REQ-014 SHALL clear EN on expiry when AUTO=0 (one-shot); AUTO=1 keeps EN.
REQ-015 SHALL clear STAT bits where written data bit is 1; a set event in the same cycle wins over clear.
REQ-016 SHALL ignore RELOAD writes for the running count until next load; CTL write and expiry in same cycle: CTL write wins, no STAT.TMR set.
REQ-017 SHALL drive xINT0_P high for exactly 3 cycles starting the cycle after STAT.TMR 0->1 while IEN[0]=1; xINT1_P same for STAT.GPIE with IEN[1].
REQ-018 SHALL not retrigger or extend a pulse already in progress; STAT bit still records the event.
REQ-019 SHALL never alter state on xRSTROBE_P alone (reads side-effect-free).

Reset
REQ-020 SHALL, while xRESET_P=1 at a clock edge, set GPO, RELOAD, CTL, STAT, IEN, CNT, xINPORT_P to 0x00 and xINT0_P/xINT1_P to 0.
REQ-021 SHALL abort in-progress pulses and timer on reset; synchronizer flops reset to 0, so GPI high at reset release yields GPIE 2 cycles later.
REQ-022 SHALL ignore strobes in any cycle xRESET_P=1.

Configuration
REQ-023 SHALL compile the timer only when ICF3Z_IODEV_TIMER_EN is defined.
REQ-024 SHALL, without ICF3Z_IODEV_TIMER_EN, treat 0x02/0x03 as unmapped (read 0x00), keep STAT.TMR 0, xINT0_P constantly 0.

Verification
REQ-025 SHALL cover: write 0xA5 to 0x00 via xWSTROBEK_P -> xGPO_P=0xA5 next cycle; PORTID=0x00 -> xINPORT_P=0xA5 one cycle later.
REQ-026 SHALL cover: RELOAD=0x04, IEN=0x01, CTL=0x03 -> STAT.TMR every 5 cycles; xINT0_P high 3 cycles per expiry.
REQ-027 SHALL cover: CTL=0x01, RELOAD=0x02 -> single expiry after 3 cycles, CTL reads 0x00 afterwards.
REQ-028 SHALL cover: xGPI_P[0] 0->1 with IEN=0x02 -> STAT=0x02 after 2-flop delay, xINT1_P 3-cycle pulse; write 0x02 to 0x04 -> STAT=0x00.
REQ-029 SHALL cover: W1C of STAT.TMR coincident with expiry -> STAT.TMR stays 1; second GPI edge during xINT1_P pulse -> pulse still 3 cycles.
REQ-030 SHALL cover: xRESET_P asserted mid-pulse and mid-count -> all outputs 0x00/0 next edge; build without ICF3Z_IODEV_TIMER_EN -> 0x03 reads 0x00, xINT0_P never high.
